// File: rtl/jellyvl_etherneco_ring_tx_arbiter.sv
// rtl/jellyvl_etherneco_ring_tx_arbiter.sv - packet-granular arbiter of forward/local byte streams onto the ring link
// Registered output stage, programmable inter-packet gap, stall/restart truncation with a 0x00 last byte.
module jellyvl_etherneco_ring_tx_arbiter #(
   parameter int FW_PRIORITY = 1,
   parameter int GAP_CYCLES  = 12,
   parameter int TIMEOUT     = 64,
   parameter int COUNT_WIDTH = 8
) (
   input  logic       reset,
   input  logic       clk,

   input  logic       s_fw_first,
   input  logic       s_fw_last,
   input  logic [7:0] s_fw_data,
   input  logic       s_fw_valid,
   output logic       s_fw_ready,

   input  logic       s_loc_first,
   input  logic       s_loc_last,
   input  logic [7:0] s_loc_data,
   input  logic       s_loc_valid,
   output logic       s_loc_ready,

   output logic       m_tx_first,
   output logic       m_tx_last,
   output logic [7:0] m_tx_data,
   output logic       m_tx_valid,
   input  logic       m_tx_ready,

   output logic       grant_fw,
   output logic       grant_loc,
   output logic       abort,
   output logic       drop
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FW,
      ST_LOC,
      ST_ABORT,
      ST_GAP
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] GAP_LOAD = COUNT_WIDTH'(GAP_CYCLES);
   localparam logic [COUNT_WIDTH-1:0] TMO_LAST = COUNT_WIDTH'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;

   state_t                 state, state_next;
   logic                   rr_loc, rr_loc_next;
   logic                   started, started_next;
   logic [COUNT_WIDTH-1:0] tmo_cnt, tmo_next;
   logic [COUNT_WIDTH-1:0] gap_cnt, gap_next;
   logic                   gap_run, gap_run_next;
   logic                   abort_next, drop_next;

   logic                   tx_valid, tx_first, tx_last;
   logic [7:0]             tx_data;
   logic                   load, ld_first, ld_last;
   logic [7:0]             ld_data;

   logic                   can_accept;
   logic                   g_valid, g_first, g_last;
   logic [7:0]             g_data;
   logic                   fw_cand, loc_cand, fw_drop, loc_drop;

   assign can_accept = !tx_valid || m_tx_ready;

   assign g_valid = (state == ST_FW) ? s_fw_valid : s_loc_valid;
   assign g_first = (state == ST_FW) ? s_fw_first : s_loc_first;
   assign g_last  = (state == ST_FW) ? s_fw_last  : s_loc_last;
   assign g_data  = (state == ST_FW) ? s_fw_data  : s_loc_data;

   assign fw_cand  = s_fw_valid  && s_fw_first;
   assign loc_cand = s_loc_valid && s_loc_first;
   assign fw_drop  = s_fw_valid  && !s_fw_first;
   assign loc_drop = s_loc_valid && !s_loc_first;

   always_comb begin
      state_next   = state;
      rr_loc_next  = rr_loc;
      started_next = started;
      tmo_next     = tmo_cnt;
      gap_next     = gap_cnt;
      gap_run_next = gap_run;
      abort_next   = 1'b0;
      drop_next    = 1'b0;
      s_fw_ready   = 1'b0;
      s_loc_ready  = 1'b0;
      load         = 1'b0;
      ld_first     = g_first;
      ld_last      = g_last;
      ld_data      = g_data;

      case (state)
         ST_IDLE: begin
            // headless beats (tails of truncated packets) are swallowed here
            s_fw_ready   = fw_drop;
            s_loc_ready  = loc_drop;
            drop_next    = fw_drop || loc_drop;
            started_next = 1'b0;
            tmo_next     = '0;
            if (fw_cand && loc_cand) begin
               if (FW_PRIORITY != 0 || !rr_loc) begin
                  state_next = ST_FW;
               end else begin
                  state_next = ST_LOC;
               end
               if (FW_PRIORITY == 0) begin
                  rr_loc_next = !rr_loc;
               end
            end else if (fw_cand) begin
               state_next = ST_FW;
            end else if (loc_cand) begin
               state_next = ST_LOC;
            end
         end

         ST_FW, ST_LOC: begin
            if (state == ST_FW) begin
               s_fw_ready = can_accept;
            end else begin
               s_loc_ready = can_accept;
            end
            if (g_valid) begin
               if (can_accept) begin
                  load         = 1'b1;
                  tmo_next     = '0;
                  started_next = 1'b1;
                  if (g_first && started) begin
                     ld_first   = 1'b0;
                     ld_last    = 1'b1;
                     ld_data    = 8'h00;
                     abort_next = 1'b1;
                     state_next = ST_GAP;
                  end else if (g_last) begin
                     state_next = ST_GAP;
                  end
               end
            end else if (TIMEOUT > 0 && tmo_cnt >= TMO_LAST) begin
               state_next = ST_ABORT;
            end else if (tmo_cnt != CNT_MAX) begin
               tmo_next = tmo_cnt + 1'b1;
            end
         end

         ST_ABORT: begin
            if (can_accept) begin
               load       = 1'b1;
               ld_first   = 1'b0;
               ld_last    = 1'b1;
               ld_data    = 8'h00;
               abort_next = 1'b1;
               state_next = ST_GAP;
            end
         end

         ST_GAP: begin
            // gap is timed from the moment the closing beat leaves the link
            if (!gap_run) begin
               if (tx_valid && m_tx_ready && tx_last) begin
                  gap_run_next = 1'b1;
                  gap_next     = GAP_LOAD;
               end
            end else if (gap_cnt == '0) begin
               gap_run_next = 1'b0;
               state_next   = ST_IDLE;
            end else begin
               gap_next = gap_cnt - 1'b1;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         rr_loc   <= 1'b0;
         started  <= 1'b0;
         tmo_cnt  <= '0;
         gap_cnt  <= '0;
         gap_run  <= 1'b0;
         tx_valid <= 1'b0;
         abort    <= 1'b0;
         drop     <= 1'b0;
      end else begin
         state    <= state_next;
         rr_loc   <= rr_loc_next;
         started  <= started_next;
         tmo_cnt  <= tmo_next;
         gap_cnt  <= gap_next;
         gap_run  <= gap_run_next;
         abort    <= abort_next;
         drop     <= drop_next;
         if (can_accept) begin
            tx_valid <= load;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         tx_first <= ld_first;
         tx_last  <= ld_last;
         tx_data  <= ld_data;
      end
   end

   assign m_tx_valid = tx_valid;
   assign m_tx_first = tx_first;
   assign m_tx_last  = tx_last;
   assign m_tx_data  = tx_data;

   assign grant_fw  = (state == ST_FW);
   assign grant_loc = (state == ST_LOC);

endmodule
